mem_if: RTL and testbench
=========================

Name: mem_if

Overview:
- Memory-interface stage (MAR/MDR plus access FSM) of the LC-3b datapath.
- Captures addresses and store data from the 16-bit data bus and runs word or byte accesses against a ready-handshaked memory port.
- Formats load data (byte select with sign-extension) and drives it back onto the bus, where the register file captures it.
- Raises R (ready) to the control FSM and flags unaligned and timeout faults.

Parameters:
TIMEOUT, 255, BUSY cycles without mem_ready before an access is aborted with a timeout error (1..65535)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
bus_in  input  16  datapath bus value
ld_mar  input  1  load MAR from bus_in
ld_mdr  input  1  load MDR from bus_in (only when mio_en=0)
mio_en  input  1  request memory access
r_w  input  1  1=write, 0=read
data_size  input  1  1=word, 0=byte
mdr_out  output  16  formatted MDR value for the bus gate
mar_out  output  16  current MAR
ready  output  1  R: access complete, one-cycle pulse
err  output  2  00 ok, 01 unaligned, 10 timeout; valid only while ready=1
mem_addr  output  16  {MAR[15:1],1'b0}
mem_wdata  output  16  MDR
mem_en  output  1  access strobe
mem_we  output  1  write strobe
mem_be  output  2  byte enables
mem_rdata  input  16  read data
mem_ready  input  1  memory completion; sampled only in BUSY

Behaviour:
- Reset (sync): MAR=0, MDR=0, state=IDLE, timeout counter=0.
  - ready=0, err=00, mem_en=0, mem_we=0.
  - rst during BUSY aborts the access: mem_en=0 from the cycle after the reset edge, and no ready pulse is generated.
- States: IDLE, BUSY, DONE, WAIT.
- IDLE:
  - ld_mar: MAR<=bus_in.
  - ld_mdr with mio_en=0 and data_size=1: MDR<=bus_in.
  - ld_mdr with mio_en=0 and data_size=0: MDR<={bus_in[7:0],bus_in[7:0]}.
  - mio_en=1, data_size=1, MAR[0]=1: -> DONE with err=01; no memory access is issued.
  - mio_en=1 otherwise: -> BUSY; latch r_w and data_size into access registers.
- BUSY:
  - mem_en=1; mem_we=latched r_w.
  - mem_be=11 for a word access; for a byte access, 01 if MAR[0]=0, 10 if MAR[0]=1.
  - ld_mar and ld_mdr are ignored (MAR/MDR stable for the whole access).
  - Counter increments every cycle.
  - mem_ready=1: on a read, MDR<=mem_rdata (raw word); -> DONE with err=00.
  - Else, if counter reaches TIMEOUT-1: -> DONE with err=10; MDR unchanged.
  - mem_ready wins over timeout when both occur in the same cycle.
- DONE: ready=1 for exactly this cycle; err holds its code; mem_en=0.
  - Next state: WAIT if mio_en=1, else IDLE.
- WAIT: stays until mio_en=0, then -> IDLE. Prevents re-issue while the control FSM still holds mio_en. ld_mar and ld_mdr are honoured as in IDLE.
- ready, err, mem_en, mem_we and mem_be are decoded from registered state only; none is combinational from inputs.
- Latency:
  - Minimum access: mio_en sampled at edge 0; mem_en high cycle 1; mem_ready high cycle 1; ready high cycle 2.
  - Unaligned fault: ready high in cycle 1.
- mdr_out is combinational from MDR, MAR[0] and the current data_size:
  - word: MDR.
  - byte with MAR[0]=0: sign-extend MDR[7:0].
  - byte with MAR[0]=1: sign-extend MDR[15:8].
- mem_addr always reflects MAR with bit 0 cleared; mem_wdata always equals MDR.
- mem_ready outside BUSY is ignored.

Test Plan:
- Word read: MAR<=0x3000; mio_en=1, r_w=0, data_size=1; mem_ready=1 on the 1st BUSY cycle with mem_rdata=0xBEEF -> mem_addr=0x3000, mem_be=11, ready pulses once with err=00, mdr_out=0xBEEF.
- Byte load with sign-extension: MAR=0x3001, data_size=0, mem_rdata=0x80_7F.
  - mdr_out=0xFF80.
  - With MAR=0x3000: mdr_out=0x007F.
- Byte store: bus_in=0x1234, ld_mdr, data_size=0 -> MDR=0x3434; MAR=0x4001, write -> mem_we=1, mem_be=10, mem_wdata=0x3434.
- Unaligned word: MAR=0x0005, mio_en=1, data_size=1 -> mem_en never asserts; ready=1 with err=01 one cycle later.
- Timeout and hold: TIMEOUT=4, mem_ready held low, mio_en held high.
  - ready with err=10 after 4 BUSY cycles; no second access while mio_en stays high.
  - ld_mdr during BUSY leaves MDR unchanged.
- Reset mid-access: assert rst in the 2nd BUSY cycle, then drive mem_ready=1 -> mem_en=0, MAR=MDR=0, ready never pulses, state IDLE.

Source files
------------

// File: rtl/mem_if_if.sv
// Memory-port bundle between the LC-3b memory-interface stage and memory.
// The master drives address, data and strobes; the slave returns read data and completion.
interface mem_if_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_en, mem_we, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_en, mem_we, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_if.sv
// LC-3b memory-interface stage: MAR/MDR registers plus the access FSM that runs
// word/byte accesses against a ready-handshaked memory port.
module mem_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        data_size,
    output logic [15:0] mdr_out,
    output logic [15:0] mar_out,
    output logic        ready,
    output logic [1:0]  err,
    mem_if_if.master    mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [1:0]  ERR_OK      = 2'b00;
    localparam logic [1:0]  ERR_UNALIGN = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT = 2'b10;
    localparam logic [15:0] CNT_LAST    = 16'(TIMEOUT - 32'd1);

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;
    logic        rw_q, rw_d;
    logic        size_q, size_d;
    logic        ld_ok_s;

    // Next-state, register-load and access-bookkeeping logic
    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rw_d    = rw_q;
        size_d  = size_q;
        ld_ok_s = (state_q == ST_IDLE) || (state_q == ST_WAIT);

        if (ld_ok_s && ld_mar) begin
            mar_d = bus_in;
        end else begin
            mar_d = mar_q;
        end

        // Byte stores replicate the low byte so either lane carries the data
        if (ld_ok_s && ld_mdr && !mio_en) begin
            mdr_d = data_size ? bus_in : {bus_in[7:0], bus_in[7:0]};
        end else if ((state_q == ST_BUSY) && mem.mem_ready && !rw_q) begin
            mdr_d = mem.mem_rdata;
        end else begin
            mdr_d = mdr_q;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 16'd0;
                if (mio_en) begin
                    if (data_size && mar_q[0]) begin
                        state_d = ST_DONE;
                        err_d   = ERR_UNALIGN;
                    end else begin
                        state_d = ST_BUSY;
                        err_d   = ERR_OK;
                        rw_d    = r_w;
                        size_d  = data_size;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (mem.mem_ready) begin
                    state_d = ST_DONE;
                    err_d   = ERR_OK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = mio_en ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                state_d = mio_en ? ST_WAIT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mar_q   <= 16'd0;
            mdr_q   <= 16'd0;
            cnt_q   <= 16'd0;
            err_q   <= ERR_OK;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
        end
    end

    // Handshake and strobe outputs decoded purely from registered state
    always_comb begin
        ready         = (state_q == ST_DONE);
        err           = ERR_OK;
        mem.mem_en    = (state_q == ST_BUSY);
        mem.mem_we    = 1'b0;
        mem.mem_be    = 2'b00;
        mem.mem_addr  = {mar_q[15:1], 1'b0};
        mem.mem_wdata = mdr_q;
        mar_out       = mar_q;
        if (state_q == ST_DONE) begin
            err = err_q;
        end else begin
            err = ERR_OK;
        end
        if (state_q == ST_BUSY) begin
            mem.mem_we = rw_q;
            if (size_q) begin
                mem.mem_be = 2'b11;
            end else begin
                mem.mem_be = mar_q[0] ? 2'b10 : 2'b01;
            end
        end else begin
            mem.mem_we = 1'b0;
            mem.mem_be = 2'b00;
        end
    end

    // Load-data formatting for the bus gate
    always_comb begin
        mdr_out = mdr_q;
        case ({data_size, mar_q[0]})
            2'b00:   mdr_out = {{8{mdr_q[7]}}, mdr_q[7:0]};
            2'b01:   mdr_out = {{8{mdr_q[15]}}, mdr_q[15:8]};
            2'b10:   mdr_out = mdr_q;
            2'b11:   mdr_out = mdr_q;
            default: mdr_out = mdr_q;
        endcase
    end

endmodule

// File: tb/tb_mem_if.sv
// Self-checking bench for mem_if: directed scenarios with a queue scoreboard of
// expected {err, mdr_out} values popped whenever ready pulses.
module tb_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic        ld_mar, ld_mdr, mio_en, r_w, data_size;
    logic [15:0] mdr_out, mar_out;
    logic        ready;
    logic [1:0]  err;

    mem_if_if mem();

    mem_if #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .data_size (data_size),
        .mdr_out   (mdr_out),
        .mar_out   (mar_out),
        .ready     (ready),
        .err       (err),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] v);
        bus_in = v; ld_mar = 1'b1; step(); ld_mar = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v, input logic sz);
        bus_in = v; ld_mdr = 1'b1; data_size = sz; mio_en = 1'b0; step(); ld_mdr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mio_en = 1'b1; data_size = 1'b1;
        step(); step();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
        checks++; if (mem.mem_en !== 1'b0 || mem.mem_we !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", mem.mem_en, mem.mem_we); end
        checks++; if (mar_out !== 16'h0000 || mdr_out !== 16'h0000) begin failures++; $display("FAIL reset_regs got=%h/%h exp=0000/0000", mar_out, mdr_out); end
        mio_en = 1'b0; rst = 1'b0; step();
    endtask

    task automatic test_word_read();
        logic [17:0] e;
        load_mar(16'h3000);
        mem.mem_rdata = 16'hBEEF; mem.mem_ready = 1'b1;
        r_w = 1'b0; data_size = 1'b1; mio_en = 1'b1;
        exp_q.push_back({2'b00, 16'hBEEF});
        step();
        checks++; if (mem.mem_en !== 1'b1 || mem.mem_we !== 1'b0) begin failures++; $display("FAIL wr_strobe got=%b%b exp=10", mem.mem_en, mem.mem_we); end
        checks++; if (mem.mem_addr !== 16'h3000) begin failures++; $display("FAIL wr_addr got=%h exp=3000", mem.mem_addr); end
        checks++; if (mem.mem_be !== 2'b11) begin failures++; $display("FAIL wr_be got=%b exp=11", mem.mem_be); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wr_early_ready got=%b exp=0", ready); end
        step();
        e = exp_q.pop_front();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", ready); end
        checks++; if (err !== e[17:16] || mdr_out !== e[15:0]) begin failures++; $display("FAIL wr_data got=%b/%h exp=%b/%h", err, mdr_out, e[17:16], e[15:0]); end
        mio_en = 1'b0; mem.mem_ready = 1'b0;
        step();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wr_pulse got=%b exp=0", ready); end
    endtask

    task automatic test_byte_load();
        logic [17:0] e;
        load_mar(16'h3001);
        data_size = 1'b0; r_w = 1'b0; mem.mem_rdata = 16'h807F; mem.mem_ready = 1'b1; mio_en = 1'b1;
        exp_q.push_back({2'b00, 16'hFF80});
        step();
        checks++; if (mem.mem_be !== 2'b10 || mem.mem_addr !== 16'h3000) begin failures++; $display("FAIL bl_be_addr got=%b/%h exp=10/3000", mem.mem_be, mem.mem_addr); end
        step();
        e = exp_q.pop_front();
        checks++; if (ready !== 1'b1 || err !== e[17:16] || mdr_out !== e[15:0]) begin failures++; $display("FAIL bl_hi got=%b/%b/%h exp=1/%b/%h", ready, err, mdr_out, e[17:16], e[15:0]); end
        mio_en = 1'b0; mem.mem_ready = 1'b0;
        step();
        load_mar(16'h3000);
        checks++; if (mdr_out !== 16'h007F) begin failures++; $display("FAIL bl_lo got=%h exp=007F", mdr_out); end
    endtask

    task automatic test_byte_store();
        logic [17:0] e;
        load_mdr(16'h1234, 1'b0);
        checks++; if (mem.mem_wdata !== 16'h3434) begin failures++; $display("FAIL bs_mdr got=%h exp=3434", mem.mem_wdata); end
        load_mar(16'h4001);
        r_w = 1'b1; data_size = 1'b0; mem.mem_ready = 1'b0; mio_en = 1'b1;
        step();
        checks++; if (mem.mem_en !== 1'b1 || mem.mem_we !== 1'b1 || mem.mem_be !== 2'b10) begin failures++; $display("FAIL bs_strobe got=%b%b%b exp=1110", mem.mem_en, mem.mem_we, mem.mem_be); end
        checks++; if (mem.mem_wdata !== 16'h3434 || mem.mem_addr !== 16'h4000) begin failures++; $display("FAIL bs_bus got=%h/%h exp=3434/4000", mem.mem_wdata, mem.mem_addr); end
        mem.mem_ready = 1'b1;
        exp_q.push_back({2'b00, 16'h0034});
        step();
        e = exp_q.pop_front();
        checks++; if (ready !== 1'b1 || err !== e[17:16] || mdr_out !== e[15:0]) begin failures++; $display("FAIL bs_done got=%b/%b/%h exp=1/%b/%h", ready, err, mdr_out, e[17:16], e[15:0]); end
        mio_en = 1'b0; mem.mem_ready = 1'b0; r_w = 1'b0;
        step();
    endtask

    task automatic test_unaligned();
        load_mar(16'h0005);
        data_size = 1'b1; r_w = 1'b0; mio_en = 1'b1;
        step();
        checks++; if (mem.mem_en !== 1'b0) begin failures++; $display("FAIL ua_en got=%b exp=0", mem.mem_en); end
        checks++; if (ready !== 1'b1 || err !== 2'b01) begin failures++; $display("FAIL ua_ready got=%b/%b exp=1/01", ready, err); end
        mio_en = 1'b0;
        step();
        checks++; if (ready !== 1'b0 || mem.mem_en !== 1'b0) begin failures++; $display("FAIL ua_after got=%b/%b exp=0/0", ready, mem.mem_en); end
    endtask

    task automatic test_timeout();
        logic [17:0] e;
        int busy, n, extra;
        bit seen;
        load_mdr(16'hA5A5, 1'b1);
        load_mar(16'h3000);
        r_w = 1'b0; data_size = 1'b1; mem.mem_ready = 1'b0; mio_en = 1'b1;
        exp_q.push_back({2'b10, 16'hA5A5});
        step();
        bus_in = 16'h5555; ld_mdr = 1'b1;
        busy = 0; n = 0; seen = 1'b0;
        while (n < 20 && !seen) begin
            if (ready) seen = 1'b1;
            else begin
                if (mem.mem_en) busy++;
                step();
                n++;
            end
        end
        ld_mdr = 1'b0;
        e = exp_q.pop_front();
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL to_seen got=%b exp=1", seen); end
        checks++; if (busy != 4) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=4", busy); end
        checks++; if (err !== e[17:16] || mdr_out !== e[15:0]) begin failures++; $display("FAIL to_done got=%b/%h exp=%b/%h", err, mdr_out, e[17:16], e[15:0]); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ready || mem.mem_en) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL to_hold got=%0d exp=0", extra); end
        mio_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int extra;
        load_mar(16'h1234);
        load_mdr(16'h0F0F, 1'b1);
        r_w = 1'b0; data_size = 1'b1; mem.mem_ready = 1'b0; mio_en = 1'b1;
        step();
        checks++; if (mem.mem_en !== 1'b1) begin failures++; $display("FAIL rm_busy got=%b exp=1", mem.mem_en); end
        step();
        rst = 1'b1; mem.mem_ready = 1'b1; mem.mem_rdata = 16'hDEAD;
        step();
        checks++; if (mem.mem_en !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL rm_abort got=%b/%b exp=0/0", mem.mem_en, ready); end
        checks++; if (mar_out !== 16'h0000 || mdr_out !== 16'h0000) begin failures++; $display("FAIL rm_regs got=%h/%h exp=0000/0000", mar_out, mdr_out); end
        rst = 1'b0; mio_en = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ready || mem.mem_en) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL rm_idle got=%0d exp=0", extra); end
        mem.mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        logic [15:0] addr, data;
        int n;
        for (int k = 0; k < 4; k++) begin
            addr = 16'($urandom) & 16'hFFFE;
            data = 16'($urandom);
            load_mar(addr);
            mem.mem_rdata = data; mem.mem_ready = 1'b1;
            r_w = 1'b0; data_size = 1'b1; mio_en = 1'b1;
            exp_q.push_back({2'b00, data});
            step();
            checks++; if (mem.mem_addr !== addr) begin failures++; $display("FAIL bb_addr got=%h exp=%h", mem.mem_addr, addr); end
            n = 0;
            while (n < 10 && !ready) begin step(); n++; end
            checks++;
            if (!ready) begin
                failures++; $display("FAIL bb_timeout got=noready exp=ready");
                void'(exp_q.pop_front());
            end else begin
                e = exp_q.pop_front();
                if (err !== e[17:16] || mdr_out !== e[15:0]) begin failures++; $display("FAIL bb_data got=%b/%h exp=%b/%h", err, mdr_out, e[17:16], e[15:0]); end
            end
            mio_en = 1'b0;
            step();
        end
        mem.mem_ready = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; bus_in = 16'h0000; ld_mar = 1'b0; ld_mdr = 1'b0;
        mio_en = 1'b0; r_w = 1'b0; data_size = 1'b1;
        mem.mem_ready = 1'b0; mem.mem_rdata = 16'h0000;
        test_reset();
        test_word_read();
        test_byte_load();
        test_byte_store();
        test_unaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
